// File: rtl/dm_access_arbiter_pkg.sv
// Shared definitions for the data-memory access arbiter.
//   - access size codes (A_type/B_type encodings)
//   - FSM state encodings
//   - DM_END: default data SRAM depth in words
//   - norm_type(): maps the unused size code 2'b11 onto a word access
package dm_access_arbiter_pkg;

  localparam logic [1:0] TYPE_W = 2'b00;
  localparam logic [1:0] TYPE_H = 2'b01;
  localparam logic [1:0] TYPE_B = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RSP  = 3'd3;
  localparam logic [2:0] S_MRG  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int DM_END = 3072;

  function automatic logic [1:0] norm_type(input logic [1:0] t);
    return (t == 2'b11) ? TYPE_W : t;
  endfunction

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Bus bundle for the data-memory access arbiter.
//   A_* : CPU M-stage requester (priority port)
//   B_* : DMA/debug requester
//   mem_*: single-port, synchronous-read data SRAM
// Modports: slave = arbiter view, master = requester/SRAM environment view.
interface dm_access_arbiter_if #(
  parameter int AW = 12
) ();

  logic        A_req;
  logic        A_we;
  logic [31:0] A_addr;
  logic [31:0] A_wdata;
  logic [1:0]  A_type;
  logic        A_done;
  logic        A_err;
  logic [31:0] A_rdata;

  logic        B_req;
  logic        B_we;
  logic [31:0] B_addr;
  logic [31:0] B_wdata;
  logic [1:0]  B_type;
  logic        B_done;
  logic        B_err;
  logic [31:0] B_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  A_req, A_we, A_addr, A_wdata, A_type,
    output A_done, A_err, A_rdata,
    input  B_req, B_we, B_addr, B_wdata, B_type,
    output B_done, B_err, B_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output A_req, A_we, A_addr, A_wdata, A_type,
    input  A_done, A_err, A_rdata,
    output B_req, B_we, B_addr, B_wdata, B_type,
    input  B_done, B_err, B_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_access_arbiter_lane_unit.sv
// Combinational byte/half lane logic for the data-memory arbiter.
//   word_i  : 32-bit word read from the SRAM
//   off_i   : byte offset addr[1:0]
//   type_i  : normalised access size
//   wdata_i : store data, lane-aligned from bit 0
//   load_o  : addressed lane, zero-extended (whole word for word access)
//   merge_o : word_i with the addressed lane replaced by store data
module dm_lane_unit
  import dm_access_arbiter_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    case (type_i)
      TYPE_B: begin
        case (off_i)
          2'd0: begin
            load_o  = {24'b0, word_i[7:0]};
            merge_o = {word_i[31:8], wdata_i[7:0]};
          end
          2'd1: begin
            load_o  = {24'b0, word_i[15:8]};
            merge_o = {word_i[31:16], wdata_i[7:0], word_i[7:0]};
          end
          2'd2: begin
            load_o  = {24'b0, word_i[23:16]};
            merge_o = {word_i[31:24], wdata_i[7:0], word_i[15:0]};
          end
          default: begin
            load_o  = {24'b0, word_i[31:24]};
            merge_o = {wdata_i[7:0], word_i[23:0]};
          end
        endcase
      end
      TYPE_H: begin
        if (off_i[1]) begin
          load_o  = {16'b0, word_i[31:16]};
          merge_o = {wdata_i[15:0], word_i[15:0]};
        end else begin
          load_o  = {16'b0, word_i[15:0]};
          merge_o = {word_i[31:16], wdata_i[15:0]};
        end
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Data-memory access arbiter: shares one single-port sync-read SRAM between
// port A (CPU, priority) and port B (DMA/debug). Sub-word stores become
// read-modify-write; loads return the zero-extended lane; misaligned or
// out-of-range accesses complete with err and never write the SRAM.
// Ports:
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : requester A/B handshakes and SRAM signals (slave modport)
module dm_access_arbiter
  import dm_access_arbiter_pkg::*;
#(
  parameter int DEPTH      = DM_END,
  parameter int AW         = 12,
  parameter int STARVE_LIM = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  dm_access_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  logic          port_q, port_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    type_q, type_d;

  logic          grant_a, grant_b;
  logic          sel_we;
  logic [31:0]   sel_addr, sel_wdata;
  logic [1:0]    sel_type;
  logic [31:0]   lane_load, lane_merge;
  logic          done, err;
  logic [31:0]   rdata;

  function automatic logic addr_err(input logic [31:0] a, input logic [1:0] t);
    logic bad_align, bad_range;
    bad_align = (t == TYPE_H && a[0]) || (t == TYPE_W && a[1:0] != 2'b00);
    bad_range = (32'(a[AW+1:2]) >= 32'(DEPTH)) || (a[31:AW+2] != '0);
    return bad_align | bad_range;
  endfunction

  // B only overrides A's priority once A has been granted LIM times in a row
  // while B was waiting.
  always_comb begin
    grant_b   = bus.B_req && (!bus.A_req || starve_q == LIM);
    grant_a   = bus.A_req && !grant_b;
    sel_we    = grant_b ? bus.B_we    : bus.A_we;
    sel_addr  = grant_b ? bus.B_addr  : bus.A_addr;
    sel_wdata = grant_b ? bus.B_wdata : bus.A_wdata;
    sel_type  = norm_type(grant_b ? bus.B_type : bus.A_type);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          we_d    = sel_we;
          port_d  = grant_b;
          addr_d  = sel_addr[AW+1:0];
          wdata_d = sel_wdata;
          type_d  = sel_type;
          if (addr_err(sel_addr, sel_type))          state_d = S_ERR;
          else if (sel_we && sel_type == TYPE_W)     state_d = S_WR;
          else                                       state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_MRG : S_RSP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.B_req)
      starve_d = '0;
    else if (state_q == S_IDLE && grant_b)
      starve_d = '0;
    else if (state_q == S_IDLE && grant_a && starve_q != LIM)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      type_q   <= TYPE_W;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      type_q   <= type_d;
    end
  end

  dm_lane_unit u_lane (
    .word_i  (bus.mem_rdata),
    .off_i   (addr_q[1:0]),
    .type_i  (type_q),
    .wdata_i (wdata_q),
    .load_o  (lane_load),
    .merge_o (lane_merge)
  );

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    done          = 1'b0;
    err           = 1'b0;
    rdata         = '0;
    if (state_q != S_IDLE) bus.mem_addr = addr_q[AW+1:2];
    case (state_q)
      S_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = wdata_q;
        done          = 1'b1;
      end
      S_RSP: begin
        done  = 1'b1;
        rdata = lane_load;
      end
      S_MRG: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = lane_merge;
        done          = 1'b1;
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
    // Completion is visible only to the port that owns the latched op.
    bus.A_done  = done && !port_q;
    bus.A_err   = err && !port_q;
    bus.A_rdata = port_q ? 32'b0 : rdata;
    bus.B_done  = done && port_q;
    bus.B_err   = err && port_q;
    bus.B_rdata = port_q ? rdata : 32'b0;
  end

endmodule
